// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
// Watches a one-hot ring counter. It checks that every valid step is a rotate-left
// by one and declares lock after LOCK_COUNT consecutive correct steps. While locked
// it counts completed revolutions, and it flags any illegal step as a loss of lock.
module ring_phase_monitor #(
    parameter  int WIDTH      = 4,
    parameter  int LOCK_COUNT = 2,
    parameter  int REV_W      = 16,
    localparam int IDX_W      = $clog2(WIDTH),
    localparam int MC_W       = $clog2(LOCK_COUNT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] phase_in,
    input  logic             phase_valid,
    input  logic             err_clr,
    output logic             lock,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [IDX_W-1:0] phase_idx,
    output logic [REV_W-1:0] rev_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ref;
    logic [MC_W-1:0]  r_mc;

    state_t           w_nxt_state;
    logic [WIDTH-1:0] w_nxt_ref;
    logic [MC_W-1:0]  w_nxt_mc;
    logic [REV_W-1:0] w_nxt_rev;
    logic             w_err;
    logic [WIDTH-1:0] w_exp;
    logic [MC_W-1:0]  w_mc_inc;
    logic             w_onehot;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return (n == 1);
    endfunction

    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [REV_W-1:0] sat_inc(input logic [REV_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + REV_W'(1);
    endfunction

    assign w_exp    = rotl1(r_ref);
    assign w_mc_inc = r_mc + MC_W'(1);
    assign w_onehot = is_onehot(phase_in);

    // Next-state logic: classify the sample against the expected rotation
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ref   = r_ref;
        w_nxt_mc    = r_mc;
        w_nxt_rev   = rev_count;
        w_err       = 1'b0;
        if (phase_valid) begin
            case (r_state)
                HUNT: begin
                    if (w_onehot) begin
                        w_nxt_ref   = phase_in;
                        w_nxt_mc    = '0;
                        w_nxt_state = TRACK;
                    end
                end
                TRACK: begin
                    if (phase_in == w_exp) begin
                        w_nxt_ref = phase_in;
                        w_nxt_mc  = w_mc_inc;
                        if (w_mc_inc == MC_W'(LOCK_COUNT)) begin
                            w_nxt_state = LOCKED;
                        end
                    end else if (w_onehot) begin
                        // Legal-looking but out of sequence: restart the match run here
                        w_nxt_ref = phase_in;
                        w_nxt_mc  = '0;
                    end else begin
                        w_nxt_ref   = '0;
                        w_nxt_mc    = '0;
                        w_nxt_state = HUNT;
                    end
                end
                LOCKED: begin
                    if (phase_in == w_exp) begin
                        w_nxt_ref = phase_in;
                        // Leaving the MSB means the ring just wrapped to bit 0
                        if (r_ref[WIDTH-1]) begin
                            w_nxt_rev = sat_inc(rev_count);
                        end
                    end else begin
                        w_err       = 1'b1;
                        w_nxt_ref   = '0;
                        w_nxt_mc    = '0;
                        w_nxt_state = HUNT;
                    end
                end
                default: begin
                    w_nxt_ref   = '0;
                    w_nxt_mc    = '0;
                    w_nxt_state = HUNT;
                end
            endcase
        end
    end

    // State and registered outputs; err_sticky set has priority over err_clr
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= HUNT;
            r_ref      <= '0;
            r_mc       <= '0;
            lock       <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            phase_idx  <= '0;
            rev_count  <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_ref      <= w_nxt_ref;
            r_mc       <= w_nxt_mc;
            lock       <= (w_nxt_state == LOCKED);
            err_pulse  <= w_err;
            if (w_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
            phase_idx  <= (w_nxt_state == HUNT) ? '0 : idx_of(w_nxt_ref);
            rev_count  <= w_nxt_rev;
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor: a table of single-edge vectors followed by
// hand-written sequences for asynchronous reset and revolution-count saturation.
module tb_ring_phase_monitor;

    logic       clock;
    logic       reset;
    logic [3:0] phase_in;
    logic       phase_valid;
    logic       err_clr;
    logic       lock, err_pulse, err_sticky;
    logic [1:0] phase_idx;
    logic [15:0] rev_count;

    logic [3:0] phase_in2;
    logic       phase_valid2;
    logic       err_clr2;
    logic       lock2, err_pulse2, err_sticky2;
    logic [1:0] phase_idx2;
    logic [1:0] rev_count2;

    int n_vec;
    int n_miss;

    ring_phase_monitor #(.WIDTH(4), .LOCK_COUNT(2), .REV_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .phase_in   (phase_in),
        .phase_valid(phase_valid),
        .err_clr    (err_clr),
        .lock       (lock),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .phase_idx  (phase_idx),
        .rev_count  (rev_count)
    );

    ring_phase_monitor #(.WIDTH(4), .LOCK_COUNT(2), .REV_W(2)) dut_sat (
        .clock      (clock),
        .reset      (reset),
        .phase_in   (phase_in2),
        .phase_valid(phase_valid2),
        .err_clr    (err_clr2),
        .lock       (lock2),
        .err_pulse  (err_pulse2),
        .err_sticky (err_sticky2),
        .phase_idx  (phase_idx2),
        .rev_count  (rev_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [3:0] ph;
        logic       clr;
        logic       lk;
        logic       ep;
        logic       es;
        logic [1:0] idx;
        logic [15:0] rev;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [3:0] ph, input logic clr,
                                input logic lk, input logic ep, input logic es,
                                input logic [1:0] idx, input logic [15:0] rev);
        vec_t t;
        t.v = v; t.ph = ph; t.clr = clr;
        t.lk = lk; t.ep = ep; t.es = es; t.idx = idx; t.rev = rev;
        return t;
    endfunction

    task automatic check(input string name, input logic [20:0] req);
        logic [20:0] got;
        got = {lock, err_pulse, err_sticky, phase_idx, rev_count};
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got {lock,ep,es,idx,rev}=%b,%b,%b,%0d,%0d required %b,%b,%b,%0d,%0d",
                     name, got[20], got[19], got[18], got[17:16], got[15:0],
                     req[20], req[19], req[18], req[17:16], req[15:0]);
        end
    endtask

    task automatic check2(input string name, input logic [6:0] req);
        logic [6:0] got;
        got = {lock2, err_pulse2, err_sticky2, phase_idx2, rev_count2};
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got {lock,ep,es,idx,rev}=%b required %b", name, got, req);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge
    task automatic apply(input vec_t t, input string name);
        phase_valid = t.v;
        phase_in    = t.ph;
        err_clr     = t.clr;
        @(posedge clock);
        #1;
        check(name, {t.lk, t.ep, t.es, t.idx, t.rev});
        @(negedge clock);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b0;
        phase_in = 4'b0000; phase_valid = 1'b0; err_clr = 1'b0;
        phase_in2 = 4'b0000; phase_valid2 = 1'b0; err_clr2 = 1'b0;

        // Lock and wrap
        tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 4'b0100, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 1, 0, 0, 1, 1));
        // Hold with garbage on the bus
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'b0110, 0, 1, 0, 0, 1, 1));
        // Multi-hot while locked, then relock after 3 samples
        tbl.push_back(mk(1, 4'b0110, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 1, 2, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 0, 0, 1, 3, 1));
        tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 1, 0, 1, 1, 1));
        // Skip 0010 -> 1000
        tbl.push_back(mk(1, 4'b1000, 0, 0, 1, 1, 0, 1));
        // err_clr on a clean edge, relock, one more wrap
        tbl.push_back(mk(1, 4'b0001, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 4'b0100, 0, 1, 0, 0, 2, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 0, 0, 2));
        // Zero sample with err_clr on the same edge: error wins
        tbl.push_back(mk(1, 4'b0000, 1, 0, 1, 1, 0, 2));
        // Pulse lasts one cycle only
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0, 2));
        // Non-one-hot in HUNT raises nothing
        tbl.push_back(mk(1, 4'b0011, 0, 0, 0, 1, 0, 2));
        // Non-one-hot in TRACK falls back to HUNT
        tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(1, 4'b1100, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 1, 2, 2));
        // Out-of-sequence one-hot in TRACK restarts the match run
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 1, 2, 2));
        tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 1, 3, 2));
        tbl.push_back(mk(1, 4'b0001, 0, 1, 0, 1, 0, 3));
        // Stall while locked
        tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 0, 3));
        // err_clr with phase_valid low
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 3));

        #12;
        check("reset_state", 21'd0);
        check2("reset_state_sat", 7'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while locked
        apply(mk(1, 4'b0001, 0, 0, 0, 0, 0, 3), "pre_rst0");
        apply(mk(1, 4'b0010, 0, 0, 0, 0, 1, 3), "pre_rst1");
        apply(mk(1, 4'b0100, 0, 1, 0, 0, 2, 3), "pre_rst2");
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 21'd0);
        @(negedge clock);
        reset = 1'b1;
        apply(mk(1, 4'b0100, 0, 0, 0, 0, 2, 0), "post_rst0");
        apply(mk(1, 4'b1000, 0, 0, 0, 0, 3, 0), "post_rst1");
        apply(mk(1, 4'b0001, 0, 1, 0, 0, 0, 0), "post_rst2");
        phase_valid = 1'b0;

        // Revolution counter saturation on the REV_W=2 instance
        phase_valid2 = 1'b1;
        for (int s = 1; s <= 24; s++) begin
            logic [3:0] p;
            p = 4'b0001 << ((s - 1) % 4);
            phase_in2 = p;
            @(posedge clock);
            #1;
            if (s == 9)  check2("sat_rev2", {1'b1, 1'b0, 1'b0, 2'd0, 2'd2});
            if (s == 17) check2("sat_rev3", {1'b1, 1'b0, 1'b0, 2'd0, 2'd3});
            @(negedge clock);
        end
        check2("sat_hold", {1'b1, 1'b0, 1'b0, 2'd3, 2'd3});
        phase_valid2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
